cmd_arbiter: RTL and testbench

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter_if.sv | 28 ++
 rtl/cmd_arbiter.sv | 141 ++++++++++++++
 tb/tb_cmd_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_arbiter_if.sv
// cmd_arbiter_if
//   Bundles the two requester handshakes, the serial output pair and the
//   status outputs of cmd_arbiter.
//   slave  : arbiter side (takes req/cmd, drives ack, serial and status)
//   master : requester / observer side
interface cmd_arbiter_if;
    logic        req0;
    logic [7:0]  cmd0;
    logic        ack0;
    logic        req1;
    logic [7:0]  cmd1;
    logic        ack1;
    logic        data_out;
    logic        strobe_out;
    logic        busy;
    logic        grant_id;
    logic [15:0] sent_cnt;

    modport slave (
        input  req0, cmd0, req1, cmd1,
        output ack0, ack1, data_out, strobe_out, busy, grant_id, sent_cnt
    );

    modport master (
        output req0, cmd0, req1, cmd1,
        input  ack0, ack1, data_out, strobe_out, busy, grant_id, sent_cnt
    );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter
//   Round-robin arbiter between two command requesters. The granted byte is
//   captured and serialized MSB first, BIT_CYCLES clocks per bit, with a
//   strobe in the first clock of each bit, followed by GAP idle clocks.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous reset, active-high
//     bus  - cmd_arbiter_if.slave: req0/cmd0/ack0, req1/cmd1/ack1,
//            data_out, strobe_out, busy, grant_id, sent_cnt
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for a request; serial outputs low
//   ST_SHIFT | shifting the captured byte out, 8*BIT_CYCLES clocks
//   ST_GAP   | inter-command gap, GAP clocks, serial outputs low
module cmd_arbiter #(
    parameter int BIT_CYCLES = 2,
    parameter int GAP        = 4
) (
    input  logic          clk,
    input  logic          rst,
    cmd_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [3:0] BIT_TMR_LOAD = 4'(BIT_CYCLES - 1);
    localparam logic [7:0] GAP_TMR_LOAD = 8'(GAP - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  shreg_q;
    logic [3:0]  bit_tmr_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  gap_tmr_q;
    logic        grant_id_q;
    logic        last_grant_q;
    logic [15:0] sent_cnt_q;

    logic        any_req;
    logic        pick1;
    logic        bit_end;
    logic        last_bit;
    logic        gap_end;
    logic        in_shift;
    logic        bit_start;
    logic        first_cycle;

    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    always_comb begin
        any_req  = bus.req0 | bus.req1;
        pick1    = bus.req1 & (~bus.req0 | ~last_grant_q);
        bit_end  = (bit_tmr_q == 4'd0);
        last_bit = (bit_cnt_q == 3'd0);
        gap_end  = (gap_tmr_q == 8'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req)            state_d = ST_SHIFT;
            ST_SHIFT: if (bit_end && last_bit) state_d = ST_GAP;
            ST_GAP:   if (gap_end)            state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit and gap timers are down-counters reloaded on entry and compared
    // against zero for their terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q      <= 8'd0;
            bit_tmr_q    <= 4'd0;
            bit_cnt_q    <= 3'd0;
            gap_tmr_q    <= 8'd0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            sent_cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        shreg_q      <= pick1 ? bus.cmd1 : bus.cmd0;
                        grant_id_q   <= pick1;
                        last_grant_q <= pick1;
                        bit_tmr_q    <= BIT_TMR_LOAD;
                        bit_cnt_q    <= 3'd7;
                    end
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        bit_tmr_q <= BIT_TMR_LOAD;
                        shreg_q   <= {shreg_q[6:0], 1'b0};
                        if (last_bit) begin
                            gap_tmr_q  <= GAP_TMR_LOAD;
                            sent_cnt_q <= sent_cnt_q + 16'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                        end
                    end else begin
                        bit_tmr_q <= bit_tmr_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    if (!gap_end) begin
                        gap_tmr_q <= gap_tmr_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state, so reset forces them all low at once.
    always_comb begin
        in_shift    = (state_q == ST_SHIFT);
        bit_start   = in_shift && (bit_tmr_q == BIT_TMR_LOAD);
        first_cycle = bit_start && (bit_cnt_q == 3'd7);
    end

    assign bus.ack0       = first_cycle & ~grant_id_q;
    assign bus.ack1       = first_cycle &  grant_id_q;
    assign bus.data_out   = in_shift & shreg_q[7];
    assign bus.strobe_out = bit_start;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.grant_id   = grant_id_q;
    assign bus.sent_cnt   = sent_cnt_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
module tb_cmd_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_arbiter_if bus ();
    cmd_arbiter_if bus2 ();

    cmd_arbiter #(.BIT_CYCLES(2), .GAP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cmd_arbiter #(.BIT_CYCLES(1), .GAP(1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    int         tcyc;
    int         acks0, acks1, strobes, busy_cnt, gap_bad, idle_bad, nbits, hbits;
    logic       prev_strobe;
    logic [7:0] rx, hold_rx;
    int         ack_cyc[$];
    logic       ack_id[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] hold_bytes[$];
    int         strobe_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        tcyc = 0; acks0 = 0; acks1 = 0; strobes = 0; busy_cnt = 0;
        gap_bad = 0; idle_bad = 0; nbits = 0; hbits = 0;
        prev_strobe = 1'b0; rx = 8'd0; hold_rx = 8'd0;
        ack_cyc.delete(); ack_id.delete(); rx_bytes.delete();
        hold_bytes.delete(); strobe_cyc.delete();
    endtask

    // Requesters drop req in their ack cycle and scramble cmd afterwards;
    // with rearm they raise req again the cycle after, until max_acks.
    task automatic observe(input int ncyc, input bit rearm, input int max_acks);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            tcyc++;
            if (bus.busy) busy_cnt++;
            if (!bus.busy && (bus.data_out || bus.strobe_out)) idle_bad++;
            if (bus.busy && !bus.strobe_out && !prev_strobe && bus.data_out) gap_bad++;
            if (bus.strobe_out) begin
                strobes++;
                strobe_cyc.push_back(tcyc);
                rx = {rx[6:0], bus.data_out};
                nbits++;
                if (nbits == 8) begin rx_bytes.push_back(rx); nbits = 0; end
            end else if (prev_strobe) begin
                hold_rx = {hold_rx[6:0], bus.data_out};
                hbits++;
                if (hbits == 8) begin hold_bytes.push_back(hold_rx); hbits = 0; end
            end
            prev_strobe = bus.strobe_out;
            if (bus.ack0) begin
                acks0++; ack_cyc.push_back(tcyc); ack_id.push_back(bus.grant_id);
            end
            if (bus.ack1) begin
                acks1++; ack_cyc.push_back(tcyc); ack_id.push_back(bus.grant_id);
            end
            if (bus.ack0) begin
                bus.req0 = 1'b0; bus.cmd0 = ~bus.cmd0;
            end else if (rearm) begin
                bus.req0 = 1'b1;
            end
            if (bus.ack1) begin
                bus.req1 = 1'b0; bus.cmd1 = ~bus.cmd1;
            end else if (rearm) begin
                bus.req1 = 1'b1;
            end
            if (rearm && (acks0 + acks1 >= max_acks)) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         a2_cnt;
        int         a2_cyc[$];
        int         s2_cyc[$];
        logic [7:0] rx2;
        logic [5:0] seq;

        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.cmd0 = 8'h00; bus.cmd1 = 8'h00;
        bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.cmd0 = 8'h00; bus2.cmd1 = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ack0",     32'(bus.ack0), 32'd0);
        chk("rst_ack1",     32'(bus.ack1), 32'd0);
        chk("rst_data",     32'(bus.data_out), 32'd0);
        chk("rst_strobe",   32'(bus.strobe_out), 32'd0);
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_grant",    32'(bus.grant_id), 32'd0);
        chk("rst_sent_cnt", 32'(bus.sent_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single command 0xA5 at defaults
        clear_obs();
        bus.cmd0 = 8'hA5; bus.req0 = 1'b1;
        observe(30, 1'b0, 99);
        chk("a5_acks0",    32'(acks0), 32'd1);
        chk("a5_acks1",    32'(acks1), 32'd0);
        chk("a5_ack_cyc",  32'(ack_cyc.size() > 0 ? ack_cyc[0] : -1), 32'd1);
        chk("a5_strobes",  32'(strobes), 32'd8);
        chk("a5_first_strobe", 32'(strobe_cyc.size() > 0 ? strobe_cyc[0] : -1), 32'd1);
        chk("a5_strobe_span", 32'(strobe_cyc.size() == 8 ? strobe_cyc[7] - strobe_cyc[0] : -1), 32'd14);
        chk("a5_bits",     32'(rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00), 32'hA5);
        chk("a5_hold_bits", 32'(hold_bytes.size() > 0 ? hold_bytes[0] : 8'h00), 32'hA5);
        chk("a5_busy_cycles", 32'(busy_cnt), 32'd20);
        chk("a5_gap_data", 32'(gap_bad), 32'd0);
        chk("a5_idle_out", 32'(idle_bad), 32'd0);
        chk("a5_sent_cnt", 32'(bus.sent_cnt), 32'd1);
        chk("a5_grant",    32'(bus.grant_id), 32'd0);

        // Tie straight out of reset; reqs already high while reset is held
        rst = 1'b1;
        bus.cmd0 = 8'h11; bus.cmd1 = 8'h22; bus.req0 = 1'b1; bus.req1 = 1'b1;
        repeat (2) @(negedge clk);
        chk("tie_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        clear_obs();
        observe(60, 1'b0, 99);
        chk("tie_first_ack_cyc", 32'(ack_cyc.size() > 0 ? ack_cyc[0] : -1), 32'd1);
        chk("tie_ack_count", 32'(ack_cyc.size()), 32'd2);
        chk("tie_id0", 32'(ack_id.size() > 0 ? ack_id[0] : 1'bx), 32'd0);
        chk("tie_id1", 32'(ack_id.size() > 1 ? ack_id[1] : 1'bx), 32'd1);
        chk("tie_spacing", 32'(ack_cyc.size() > 1 ? ack_cyc[1] - ack_cyc[0] : -1), 32'd21);
        chk("tie_byte0", 32'(rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00), 32'h11);
        chk("tie_byte1", 32'(rx_bytes.size() > 1 ? rx_bytes[1] : 8'h00), 32'h22);
        chk("tie_sent_cnt", 32'(bus.sent_cnt), 32'd2);

        // Fairness: both held, re-raised after each ack, six commands
        clear_obs();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        observe(140, 1'b1, 6);
        seq = 6'd0;
        for (int i = 0; i < 6; i++) seq = {seq[4:0], (i < ack_id.size()) ? ack_id[i] : 1'b1};
        chk("fair_ack_count", 32'(ack_cyc.size()), 32'd6);
        chk("fair_grant_seq", 32'(seq), 32'b010101);
        chk("fair_span", 32'(ack_cyc.size() == 6 ? ack_cyc[5] - ack_cyc[0] : -1), 32'd105);
        chk("fair_sent_cnt", 32'(bus.sent_cnt), 32'd8);

        // Lone req1 right after requester 1 was last granted
        clear_obs();
        bus.cmd1 = 8'h5A; bus.req1 = 1'b1;
        observe(30, 1'b0, 99);
        chk("solo_acks1", 32'(acks1), 32'd1);
        chk("solo_acks0", 32'(acks0), 32'd0);
        chk("solo_grant", 32'(bus.grant_id), 32'd1);
        chk("solo_byte",  32'(rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00), 32'h5A);
        chk("solo_sent_cnt", 32'(bus.sent_cnt), 32'd9);

        // Reset after the third strobe of 0xFF
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.cmd0 = 8'hFF; bus.req0 = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.strobe_out) k++;
        end
        chk("midrst_reached_3rd_strobe", 32'(k), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_strobe", 32'(bus.strobe_out), 32'd0);
        chk("midrst_busy",   32'(bus.busy), 32'd0);
        chk("midrst_sent_cnt", 32'(bus.sent_cnt), 32'd0);
        rst = 1'b0;
        clear_obs();
        observe(40, 1'b0, 99);
        chk("midrst_no_ack", 32'(acks0 + acks1), 32'd0);
        chk("midrst_no_strobe", 32'(strobes), 32'd0);
        chk("midrst_cnt_after", 32'(bus.sent_cnt), 32'd0);

        // sent_cnt wrap
        force dut.sent_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.sent_cnt_q;
        clear_obs();
        bus.cmd0 = 8'h3C; bus.req0 = 1'b1;
        observe(30, 1'b0, 99);
        chk("wrap_acks0", 32'(acks0), 32'd1);
        chk("wrap_byte", 32'(rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00), 32'h3C);
        chk("wrap_sent_cnt", 32'(bus.sent_cnt), 32'h0000);

        // BIT_CYCLES=1, GAP=1 instance, cmd1=0x80 twice back to back
        a2_cnt = 0; rx2 = 8'd0;
        bus2.cmd1 = 8'h80; bus2.req1 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus2.strobe_out) begin
                s2_cyc.push_back(c);
                if (s2_cyc.size() <= 8) rx2 = {rx2[6:0], bus2.data_out};
            end
            if (bus2.ack1) begin
                a2_cnt++; a2_cyc.push_back(c);
                bus2.req1 = 1'b0;
            end else if (a2_cnt < 2) begin
                bus2.req1 = 1'b1;
            end
        end
        chk("bc1_ack_count", 32'(a2_cnt), 32'd2);
        chk("bc1_ack_spacing", 32'(a2_cyc.size() == 2 ? a2_cyc[1] - a2_cyc[0] : -1), 32'd10);
        chk("bc1_strobes", 32'(s2_cyc.size()), 32'd16);
        chk("bc1_strobe_run", 32'(s2_cyc.size() >= 8 ? s2_cyc[7] - s2_cyc[0] : -1), 32'd7);
        chk("bc1_first_strobe_at_ack", 32'((s2_cyc.size() > 0 && a2_cyc.size() > 0) ? s2_cyc[0] - a2_cyc[0] : -1), 32'd0);
        chk("bc1_bits", 32'(rx2), 32'h80);
        chk("bc1_sent_cnt", 32'(bus2.sent_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
